// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Downloads a program from a byte-wide host link into the instruction memory,
// then starts the processor core. The stream is big-endian: a 16-bit word
// count N, then N 16-bit words, then (optional) one XOR checksum byte.
//
// Optional feature: define LOADER_CHECKSUM_EN to require and verify a
// trailing XOR checksum of all 2*N data bytes. Without it, no checksum byte
// is taken and no XOR logic exists.
//
// Handshake: a byte moves from host to loader on a rising edge where
// i_rx_valid and o_rx_ready are both 1. o_rx_ready depends only on the state.
//
// Ports
//   i_clock       system clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_load        one-cycle request to start a download (IDLE/DONE/ERR only)
//   i_rx_data     incoming byte
//   i_rx_valid    i_rx_data is valid
//   o_rx_ready    loader accepts a byte this cycle
//   o_iram_addr   instruction-memory word address
//   o_iram_data   instruction-memory write data
//   o_iram_wren   one-cycle write strobe per word
//   o_core_start  one-cycle start pulse on successful completion
//   o_busy        download in progress
//   o_done        last download completed successfully
//   o_error       last download aborted
//   o_state       current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int DEPTH = 512
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [15:0] o_iram_addr,
    output logic [15:0] o_iram_data,
    output logic        o_iram_wren,
    output logic        o_core_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [3:0]  o_state
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LEN_HI  = 4'd1,
        S_LEN_LO  = 4'd2,
        S_DATA_HI = 4'd3,
        S_DATA_LO = 4'd4,
        S_WRITE   = 4'd5,
        S_CHECK   = 4'd6,
        S_DONE    = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    // 17 bits so that DEPTH = 65536 would still compare correctly.
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      r_state;
    logic [15:0] r_count;
    logic [15:0] r_index;
    logic [7:0]  r_data_hi;
    logic [15:0] r_iram_addr;
    logic [15:0] r_iram_data;
    logic        r_iram_wren;
    logic        r_core_start;
    logic        r_done;
    logic        r_error;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_xfer;
    logic [15:0] w_len;
    logic        w_last;

    always_comb begin
        o_rx_ready = 1'b0;
        case (r_state)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: o_rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK:                                  o_rx_ready = 1'b1;
`endif
            default:                                  o_rx_ready = 1'b0;
        endcase
    end

    assign w_xfer = i_rx_valid & o_rx_ready;
    // Full count as it will be once the low byte in LEN_LO is captured.
    assign w_len  = {r_count[15:8], i_rx_data};
    // Only evaluated in WRITE, where r_count is known to be non-zero.
    assign w_last = (r_index == (r_count - 16'd1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_count      <= 16'd0;
            r_index      <= 16'd0;
            r_data_hi    <= 8'd0;
            r_iram_addr  <= 16'd0;
            r_iram_data  <= 16'd0;
            r_iram_wren  <= 1'b0;
            r_core_start <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            r_iram_wren  <= 1'b0;
            r_core_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_load) begin
                        r_state <= S_LEN_HI;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        r_csum  <= 8'd0;
`endif
                    end
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_count[15:8] <= i_rx_data;
                        r_state       <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_count <= w_len;
                        if ({1'b0, w_len} > DEPTH_L) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                            r_done  <= 1'b0;
                        end else if (w_len == 16'd0) begin
                            r_state <= S_CHECK;
                        end else begin
                            r_index <= 16'd0;
                            r_state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (w_xfer) begin
                        r_data_hi <= i_rx_data;
`ifdef LOADER_CHECKSUM_EN
                        r_csum    <= r_csum ^ i_rx_data;
`endif
                        r_state   <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    // Memory outputs are loaded here so they are valid for
                    // exactly the one cycle spent in WRITE.
                    if (w_xfer) begin
                        r_iram_addr <= r_index;
                        r_iram_data <= {r_data_hi, i_rx_data};
                        r_iram_wren <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        r_csum      <= r_csum ^ i_rx_data;
`endif
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_index <= r_index + 16'd1;
                    r_state <= w_last ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                    if (w_xfer) begin
                        if (i_rx_data == r_csum) begin
                            r_state      <= S_DONE;
                            r_done       <= 1'b1;
                            r_error      <= 1'b0;
                            r_core_start <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
`else
                    r_state      <= S_DONE;
                    r_done       <= 1'b1;
                    r_error      <= 1'b0;
                    r_core_start <= 1'b1;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_iram_addr  = r_iram_addr;
    assign o_iram_data  = r_iram_data;
    assign o_iram_wren  = r_iram_wren;
    assign o_core_start = r_core_start;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_busy       = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign o_state      = r_state;

endmodule
